// File: rtl/adder64_pipe.sv
// adder64_pipe: registered WIDTH-bit two's-complement adder with a signed
// overflow flag, split into two carry-chained stages of WIDTH/2 bits each.
// Latency is 2 clocks and one operand pair is accepted every cycle.
// Optional feature macro ADDER64_SUB_EN adds a 'sub' input that selects
// A-B. The subtraction is computed as A+~B+1, with the +1 entering as the
// low-stage carry-in.
module adder64_pipe #(
  parameter int unsigned WIDTH = 64  // must be even; split point is WIDTH/2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ADDER64_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             overflow
);

  localparam int unsigned HALF = WIDTH / 2;

  // Operation select and effective B operand
  logic             sub_c;
  logic [WIDTH-1:0] b_eff_c;
  logic [HALF:0]    lo_sum_c;

`ifdef ADDER64_SUB_EN
  assign sub_c = sub;
`else
  assign sub_c = 1'b0;
`endif

  // For subtraction B is inverted, so the sign test below stays the same
  // for both operations: overflow occurs when the effective operands share
  // a sign and the result's sign differs from it.
  assign b_eff_c  = sub_c ? ~B : B;
  assign lo_sum_c = {1'b0, A[HALF-1:0]} + {1'b0, b_eff_c[HALF-1:0]}
                  + (HALF+1)'(sub_c);

  // Stage-1 pipeline registers
  logic            s1_valid;
  logic [HALF-1:0] s1_lo;
  logic            s1_carry;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;

  // Stage 1: low-half add; high operand halves are carried alongside
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_carry <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo    <= lo_sum_c[HALF-1:0];
        s1_carry <= lo_sum_c[HALF];
        s1_a_hi  <= A[WIDTH-1:HALF];
        s1_b_hi  <= b_eff_c[WIDTH-1:HALF];
      end
    end
  end

  // Stage-2 combinational high-half add and signed-overflow detect
  logic [HALF-1:0]  hi_sum_c;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  // The carry-out of the top bit is deliberately dropped
  assign hi_sum_c = s1_a_hi + s1_b_hi + HALF'(s1_carry);
  assign res_c    = {hi_sum_c, s1_lo};
  assign ovf_c    = (s1_a_hi[HALF-1] == s1_b_hi[HALF-1]) &&
                    (hi_sum_c[HALF-1] != s1_a_hi[HALF-1]);

  // Stage 2: output registers; the result holds while out_valid is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res      <= res_c;
        overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_adder64_pipe.sv
// tb_adder64_pipe: scoreboard bench for adder64_pipe. The driver pushes the
// expected result of every accepted operation. The monitor pops and checks
// an entry whenever out_valid is seen, and also checks the exact arrival
// cycle and the hold behaviour while out_valid is low.
// Build with +define+ADDER64_SUB_EN to also exercise subtraction.
module tb_adder64_pipe;

  localparam int unsigned W = 64;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int unsigned  cyc;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
`ifdef ADDER64_SUB_EN
  logic         sub_in;
`endif
  logic         out_valid;
  logic [W-1:0] res;
  logic         overflow;

  exp_t         sbq[$];
  int unsigned  cyc = 0;
  logic         rst_at_edge = 1'b0;
  bit           started = 1'b0;
  logic [W-1:0] last_res = '0;
  logic         last_ovf = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;

  adder64_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (a_in),
    .B        (b_in),
`ifdef ADDER64_SUB_EN
    .sub      (sub_in),
`endif
    .out_valid(out_valid),
    .res      (res),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Cycle counter and a record of whether reset was applied at each edge
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: exact signed arithmetic on sign-extended operands; signed
  // overflow means the true result does not fit in W bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit s, input int unsigned c, input string nm);
    logic [W:0] wide;
    exp_t e;
    wide   = s ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    e.res  = wide[W-1:0];
    e.ovf  = wide[W] ^ wide[W-1];
    e.cyc  = c + 2;
    e.name = nm;
    return e;
  endfunction

  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s, input string nm);
    @(posedge clk);
    #1;
    in_valid = v;
    a_in     = a;
    b_in     = b;
`ifdef ADDER64_SUB_EN
    sub_in   = s;
`endif
    if (v && rst_n) sbq.push_back(model(a, b, s, cyc, nm));
  endtask

  // Reset applied for one edge: results not yet visible are discarded
  task automatic pulse_reset();
    exp_t keep[$];
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a_in     = 64'h1234_5678_9ABC_DEF0;
    b_in     = 64'h1111_1111_1111_1111;
    foreach (sbq[i]) if (sbq[i].cyc <= cyc) keep.push_back(sbq[i]);
    sbq = keep;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = {$urandom, 32'hFFFF_FFFF};
      1:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = '1;
      4:       v = 64'(1);
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Monitor: reset values, scoreboard pop/compare, hold while idle
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_res", res, 64'(0));
      chk("reset_overflow", 64'(overflow), 64'(0));
      last_res = '0;
      last_ovf = 1'b0;
      started  = 1'b1;
    end else if (started) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got res %h with no pending op, required none (cycle %0d)",
                   res, cyc);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_res"}, res, e.res);
          chk({e.name, "_ovf"}, 64'(overflow), 64'(e.ovf));
          chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
          last_res = e.res;
          last_ovf = e.ovf;
        end
      end else begin
        chk("hold_res", res, last_res);
        chk("hold_ovf", 64'(overflow), 64'(last_ovf));
      end
    end
  end

  initial begin
    bit s;
    int unsigned budget;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a_in     = 64'hDEAD_BEEF_0000_0001;
    b_in     = 64'h0BAD_F00D_FFFF_FFFF;
`ifdef ADDER64_SUB_EN
    sub_in   = 1'b0;
`endif
    // Two reset edges with in_valid high, then release
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;

    drive(1, 64'h0, 64'h0, 0, "zero");
    drive(1, '1, '1, 0, "all_ones");
    drive(1, 64'h0000_0000_FFFF_FFFF, 64'h1, 0, "mid_carry");
    drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, "pos_ovf");
    drive(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, "neg_ovf");
    drive(0, 64'h0, 64'h0, 0, "idle");

    // Bubble pattern 1,0,1
    drive(1, 64'h0000_0001_FFFF_FFFF, 64'h0000_0001_0000_0001, 0, "bubble_a");
    drive(0, 64'hFFFF_0000_FFFF_0000, 64'h1, 0, "bubble_gap");
    drive(1, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 0, "bubble_b");
    repeat (3) drive(0, 64'h0, 64'h0, 0, "idle");

    // Reset with operations in flight: none may emerge
    drive(1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0, "flight_a");
    pulse_reset();
    repeat (4) drive(0, 64'h0, 64'h0, 0, "idle");

`ifdef ADDER64_SUB_EN
    drive(1, 64'h8000_0000_0000_0000, 64'h1, 1, "sub_ovf");
    drive(1, 64'h5, 64'h7, 1, "sub_neg");
    drive(1, 64'h0000_0001_0000_0000, 64'h1, 1, "sub_borrow");
    drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, "sub_off_add");
    drive(0, 64'h0, 64'h0, 0, "idle");
`endif

    // Randomized traffic with bubbles
    for (int i = 0; i < 400; i++) begin
      s = 1'b0;
`ifdef ADDER64_SUB_EN
      s = 1'($urandom_range(0, 1));
`endif
      drive($urandom_range(0, 3) != 0, pick(), pick(), s, "rand");
    end

    // Drain with a bounded wait
    in_valid = 1'b0;
    budget   = 0;
    while (sbq.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d results still pending, required 0", sbq.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/adder64_pipe.md
Name: adder64_pipe

Overview:
- Registered 64-bit two's-complement adder with signed-overflow flag, used in the datapath of the pipelined MIPS CPU (address/ALU add path).
- Two-stage carry-split pipeline:
  - Stage 1 adds the low 32 bits.
  - Stage 2 adds the high 32 bits using the stage-1 carry.
- Fixed latency of 2 cycles, accepts one operand pair per cycle.

Parameters:
- WIDTH, 64, operand/result width; must be even, split point is WIDTH/2.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  A/B valid this cycle.
- A  input  WIDTH  operand A, two's complement.
- B  input  WIDTH  operand B, two's complement.
- out_valid  output  1  res/overflow valid this cycle.
- res  output  WIDTH  A+B modulo 2^WIDTH.
- overflow  output  1  signed overflow of A+B.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-low (rst_n sampled on rising clk).
  - On reset: out_valid=0, res=0, overflow=0, all internal pipeline registers cleared (including valid bits).
- Stage 1 (edge n), capturing on every edge with in_valid:
  - lo_sum = A[31:0]+B[31:0] (33-bit, carry c32).
  - A[63:32] and B[63:32] registered alongside.
  - valid bit registered.
- Stage 2 (edge n+1):
  - hi = A_hi+B_hi+c32.
  - res = {hi[31:0], lo_sum[31:0]}.
  - overflow = (A[63]==B[63]) && (res[63]!=A[63]).
  - out_valid = stage-1 valid.
- Latency: inputs sampled at edge n, result visible after edge n+1 (2 edges).
- Throughput: 1 per cycle, no stall/backpressure.
- Cycles with in_valid=0:
  - Stage registers hold their previous data.
  - Valid bits clear, so out_valid drops 2 cycles later.
  - res/overflow hold their last values while out_valid=0.
- Unsigned carry-out of bit 63 is discarded (not reported). Overflow is signed only.
- Boundary cases:
  - all-ones + all-ones: res=FFFF_FFFF_FFFF_FFFE, overflow=0.
  - 7FFF..F + 1: res=8000..0, overflow=1.
  - 8000..0 + 8000..0: res=0, overflow=1.
  - Carry crossing bit 31→32 must propagate correctly across the stage boundary.
- Reset mid-operation: in-flight results discarded; out_valid=0 on the cycle after the reset edge; no stale result emerges afterwards.
- Unknown (X) input bits: no masking; X may propagate to res/overflow. Valid-path registers must never go X after reset.

Optional Feature:
- Macro ADDER64_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with A/B.
  - sub=1 computes A-B as A+~B+1, with the +1 injected as stage-1 carry-in.
  - overflow = (A[63]!=B[63]) && (res[63]!=A[63]).
  - sub=0 behaves exactly as the base adder.
- Undefined: port absent, add only.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 → out_valid=0, res=0, overflow=0; release → first result appears 2 edges after the first sampled input.
- Zero/all-ones: A=0,B=0 → res=0, ovf=0. Next cycle A=B=FFFF_FFFF_FFFF_FFFF → res=FFFF_FFFF_FFFF_FFFE, ovf=0. Back-to-back results on consecutive cycles.
- Mid-carry: A=0000_0000_FFFF_FFFF, B=1 → res=0000_0001_0000_0000, ovf=0.
- Signed overflow:
  - A=7FFF_FFFF_FFFF_FFFF, B=1 → res=8000_0000_0000_0000, ovf=1.
  - A=B=8000_0000_0000_0000 → res=0, ovf=1.
- Bubbles/reset mid-flight: in_valid pattern 1,0,1 → out_valid 1,0,1 delayed 2 cycles; assert rst_n=0 with two ops in flight → neither emerges.
- ADDER64_SUB_EN: sub=1, A=8000_0000_0000_0000, B=1 → res=7FFF_FFFF_FFFF_FFFF, ovf=1; sub=1, A=5, B=7 → res=FFFF_FFFF_FFFF_FFFE, ovf=0.
